r5p_soc_uart_avm: RTL

// - UART-driven Avalon-MM master (debug/boot loader bridge); initiator counterpart of the UART/Avalon responder peripherals.
// - Receives command frames on uart_rxd, issues one Avalon read or write per frame, returns the response on uart_txd.
// - Sits beside the CPU on the SoC interconnect as a second bus master; line format fixed 8N1, LSB first.

---
 rtl/r5p_soc_uart_avm_pkg.sv | 9 +
 rtl/r5p_soc_uart_phy.sv | 110 +++++++++++
 rtl/r5p_soc_uart_avm.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/r5p_soc_uart_avm_pkg.sv
// Shared types and constants for the UART-driven Avalon-MM master.
package r5p_soc_uart_avm_pkg;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

  localparam logic [7:0] RSP_WR_ACK     = 8'h00;
  localparam int unsigned FRM_ADDR_BYTES = 4;

endpackage

// File: rtl/r5p_soc_uart_phy.sv
// 8N1 UART line PHY: mid-bit sampling receiver and back-to-back capable transmitter.
module r5p_soc_uart_phy #(
  parameter int unsigned N_BIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       txd
);

  localparam int unsigned CW = (N_BIT > 2) ? $clog2(N_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(N_BIT - 1);
  localparam logic [CW-1:0] BIT_HALF = CW'(N_BIT / 2 - 1);

  logic          rx_s, rx_p, rx_busy;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_sh;

  // rx_s lags the pin by one cycle; loading BIT_HALF at the edge lands the sample N_BIT/2 after the fall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s     <= 1'b1;
      rx_p     <= 1'b1;
      rx_busy  <= 1'b0;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_s     <= rxd;
      rx_p     <= rx_s;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      if (!rx_busy) begin
        if (rx_p && !rx_s) begin
          rx_busy <= 1'b1;
          rx_cnt  <= BIT_HALF;
          rx_bit  <= '0;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - 1'b1;
      end else begin
        rx_cnt <= BIT_LAST;
        rx_bit <= rx_bit + 4'd1;
        if (rx_bit == 4'd0) begin
          if (rx_s) rx_busy <= 1'b0;
        end else if (rx_bit <= 4'd8) begin
          rx_sh <= {rx_s, rx_sh[7:1]};
        end else begin
          rx_busy <= 1'b0;
          if (rx_s) begin
            rx_data  <= rx_sh;
            rx_valid <= 1'b1;
          end else begin
            rx_ferr  <= 1'b1;
          end
        end
      end
    end
  end

  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [7:0]    tx_sh;

  // Ready during the last stop-bit cycle so the next start bit follows with no gap
  assign tx_ready = !tx_busy || (tx_bit == 4'd9 && tx_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txd     <= 1'b1;
      tx_busy <= 1'b0;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_sh   <= '0;
    end else if (tx_valid && tx_ready) begin
      txd     <= 1'b0;
      tx_sh   <= tx_data;
      tx_bit  <= '0;
      tx_cnt  <= BIT_LAST;
      tx_busy <= 1'b1;
    end else if (tx_busy) begin
      if (tx_cnt != '0) begin
        tx_cnt <= tx_cnt - 1'b1;
      end else if (tx_bit == 4'd9) begin
        tx_busy <= 1'b0;
      end else begin
        tx_cnt <= BIT_LAST;
        tx_bit <= tx_bit + 4'd1;
        if (tx_bit < 4'd8) begin
          txd   <= tx_sh[0];
          tx_sh <= {1'b0, tx_sh[7:1]};
        end else begin
          txd   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/r5p_soc_uart_avm.sv
// UART command frames in, one Avalon-MM read/write per frame, response bytes out.
module r5p_soc_uart_avm
  import r5p_soc_uart_avm_pkg::*;
#(
  parameter int unsigned N_BIT = 2,
  parameter int unsigned AAW   = 32,
  parameter int unsigned ADW   = 32,
  parameter int unsigned TMO   = 65535
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           uart_rxd,
  output logic           uart_txd,
  output logic           avm_read,
  output logic           avm_write,
  output logic [AAW-1:0] avm_address,
  output logic [3:0]     avm_byteenable,
  output logic [ADW-1:0] avm_writedata,
  input  logic [ADW-1:0] avm_readdata,
  input  logic           avm_waitrequest,
  output logic           err
);

  localparam int unsigned TW = $clog2(TMO + 1);

  state_t         state, state_nxt;
  logic [7:0]     rx_data;
  logic           rx_valid, rx_ferr;
  logic           tx_valid, tx_ready, tx_busy, tx_hs;
  logic [1:0]     bcnt;
  logic           wr;
  logic [3:0]     be_r;
  logic [31:0]    addr_sh;
  logic [ADW-1:0] data_sh, rsp_sh;
  logic [2:0]     rsp_left;
  logic [TW-1:0]  tmo_cnt;
  logic           cmd_ok, in_frame, tmo_hit, last_byte, err_nxt;

  r5p_soc_uart_phy #(.N_BIT(N_BIT)) u_phy (
    .clk      (clk),
    .rst      (rst),
    .rxd      (uart_rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr),
    .tx_data  (rsp_sh[7:0]),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_busy  (tx_busy),
    .txd      (uart_txd)
  );

  assign cmd_ok    = (rx_data[3:1] == 3'b000);
  assign in_frame  = (state == ADDR) || (state == DATA);
  assign last_byte = rx_valid && (bcnt == 2'(FRM_ADDR_BYTES - 1));
  // A byte completing on the expiry cycle takes priority over the timeout
  assign tmo_hit   = in_frame && !rx_valid && (tmo_cnt == TW'(TMO));
  assign tx_hs     = tx_valid && tx_ready;

  assign err_nxt = rx_ferr || tmo_hit
                || (rx_valid && state == IDLE && !cmd_ok)
                || (rx_valid && (state == BUS || state == RESP));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (rx_valid && cmd_ok) state_nxt = ADDR;
      ADDR: begin
        if (rx_ferr || tmo_hit) state_nxt = IDLE;
        else if (last_byte)     state_nxt = wr ? DATA : BUS;
      end
      DATA: begin
        if (rx_ferr || tmo_hit) state_nxt = IDLE;
        else if (last_byte)     state_nxt = BUS;
      end
      BUS:  if (!avm_waitrequest) state_nxt = RESP;
      RESP: if (rsp_left == 3'd0 && !tx_busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    avm_read  = (state == BUS) && !wr;
    avm_write = (state == BUS) && wr;
    tx_valid  = (state == RESP) && (rsp_left != 3'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err      <= 1'b0;
      bcnt     <= '0;
      wr       <= 1'b0;
      be_r     <= '0;
      addr_sh  <= '0;
      data_sh  <= '0;
      rsp_sh   <= '0;
      rsp_left <= '0;
    end else begin
      err <= err_nxt;
      unique case (state)
        IDLE: if (rx_valid && cmd_ok) begin
          be_r <= rx_data[7:4];
          wr   <= rx_data[0];
          bcnt <= '0;
        end
        ADDR: if (rx_valid) begin
          addr_sh <= {rx_data, addr_sh[31:8]};
          bcnt    <= bcnt + 2'd1;
        end
        DATA: if (rx_valid) begin
          data_sh <= {rx_data, data_sh[ADW-1:8]};
          bcnt    <= bcnt + 2'd1;
        end
        BUS: if (!avm_waitrequest) begin
          if (wr) begin
            rsp_sh   <= {{(ADW-8){1'b0}}, RSP_WR_ACK};
            rsp_left <= 3'd1;
          end else begin
            rsp_sh   <= avm_readdata;
            rsp_left <= 3'd4;
          end
        end
        RESP: if (tx_hs) begin
          rsp_sh   <= {8'h00, rsp_sh[ADW-1:8]};
          rsp_left <= rsp_left - 3'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        tmo_cnt <= '0;
    else if (!in_frame || rx_valid) tmo_cnt <= '0;
    else if (tmo_cnt != TW'(TMO))   tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign avm_address    = addr_sh[AAW-1:0];
  assign avm_byteenable = be_r;
  assign avm_writedata  = data_sh;

endmodule
